// File: rtl/fifo_rd_arbiter.sv
// Round-robin read scheduler draining NUM_Q FIFOs into one tagged stream; rden 1 cycle after grant, out_valid 2 cycles after rden.
// Reads are credit-limited against a 4-entry output buffer, so out_ready backpressure stalls q_rden without loss.
module fifo_rd_arbiter #(
  parameter int NUM_Q     = 4,
  parameter int WIDTH     = 8,
  parameter int PTR       = 4,
  parameter int MAX_BURST = 4,
  parameter int GAP_CYC   = 2
) (
  input  logic                     rdclk,
  input  logic                     reset,
  input  logic [NUM_Q-1:0]         q_en,
  input  logic [NUM_Q-1:0]         q_rdempty,
  input  logic [NUM_Q*(PTR+1)-1:0] q_rdusedw,
  input  logic [NUM_Q*WIDTH-1:0]   q_dataout,
  output logic [NUM_Q-1:0]         q_rden,
  output logic [WIDTH-1:0]         out_data,
  output logic [2:0]               out_qid,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int CW        = PTR + 1;
  localparam int QW        = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
  localparam int GW        = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam int BUF_DEPTH = 4;
  localparam int EW        = WIDTH + 4;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

  state_t          state, state_nxt;
  logic [QW-1:0]   grant, grant_nxt;
  logic [QW-1:0]   last_grant, last_grant_nxt;
  logic [CW-1:0]   remaining, remaining_nxt;
  logic [GW-1:0]   gap_cnt, gap_cnt_nxt;

  logic [NUM_Q-1:0] eligible;
  logic             pick_vld;
  logic [QW-1:0]    pick;
  logic [CW-1:0]    pick_usedw;

  logic             credit_ok;
  logic             rd_fire;
  logic             rd_vld;
  logic             rd_last;
  logic [QW-1:0]    rd_qid;
  logic [WIDTH-1:0] cap_dat;

  logic [EW-1:0]    buf_mem [BUF_DEPTH];
  logic [1:0]       buf_wr_ptr, buf_rd_ptr;
  logic [2:0]       buf_cnt;
  logic             buf_push, buf_pop;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_Q; i++)
      eligible[i] = q_en[i] && !q_rdempty[i] && (q_rdusedw[i*CW +: CW] != '0);
  end

  // Scan downwards so the queue closest after last_grant is the one left in pick.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = NUM_Q; k >= 1; k--) begin
      if (eligible[QW'((int'(last_grant) + k) % NUM_Q)]) begin
        pick_vld = 1'b1;
        pick     = QW'((int'(last_grant) + k) % NUM_Q);
      end
    end
  end

  assign pick_usedw = q_rdusedw[int'(pick)*CW +: CW];

  // Pops are not credited, which keeps q_rden free of any out_ready path.
  assign credit_ok = ({1'b0, buf_cnt} + {3'b000, rd_vld}) < 4'(BUF_DEPTH);
  assign rd_fire   = (state == S_BURST) && (remaining != '0) && credit_ok;

  always_comb begin
    q_rden = '0;
    for (int i = 0; i < NUM_Q; i++)
      q_rden[i] = rd_fire && (grant == QW'(i));
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    remaining_nxt  = remaining;
    gap_cnt_nxt    = gap_cnt;
    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          state_nxt     = S_BURST;
          grant_nxt     = pick;
          remaining_nxt = (pick_usedw > CW'(MAX_BURST)) ? CW'(MAX_BURST) : pick_usedw;
        end
      end
      S_BURST: begin
        if (rd_fire) begin
          remaining_nxt = remaining - CW'(1);
          if (remaining == CW'(1)) begin
            last_grant_nxt = grant;
            gap_cnt_nxt    = GW'(GAP_CYC);
            state_nxt      = (GAP_CYC == 0) ? S_IDLE : S_GAP;
          end
        end
      end
      S_GAP: begin
        gap_cnt_nxt = gap_cnt - GW'(1);
        if (gap_cnt <= GW'(1))
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge rdclk) begin
    if (reset) begin
      state      <= S_IDLE;
      grant      <= '0;
      last_grant <= QW'(NUM_Q - 1);
      remaining  <= '0;
      gap_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      remaining  <= remaining_nxt;
      gap_cnt    <= gap_cnt_nxt;
    end
  end

  // FIFO dataout is valid the cycle after rden, so remember what was read.
  always_ff @(posedge rdclk) begin
    if (reset) begin
      rd_vld  <= 1'b0;
      rd_qid  <= '0;
      rd_last <= 1'b0;
    end else begin
      rd_vld  <= rd_fire;
      rd_qid  <= grant;
      rd_last <= (remaining == CW'(1));
    end
  end

  assign cap_dat  = q_dataout[int'(rd_qid)*WIDTH +: WIDTH];
  assign buf_push = rd_vld;
  assign buf_pop  = out_valid && out_ready;

  always_ff @(posedge rdclk) begin
    if (reset) begin
      buf_wr_ptr <= '0;
      buf_rd_ptr <= '0;
      buf_cnt    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++)
        buf_mem[i] <= '0;
    end else begin
      if (buf_push) begin
        buf_mem[buf_wr_ptr] <= {rd_last, 3'(rd_qid), cap_dat};
        buf_wr_ptr          <= buf_wr_ptr + 2'd1;
      end
      if (buf_pop)
        buf_rd_ptr <= buf_rd_ptr + 2'd1;
      case ({buf_push, buf_pop})
        2'b10:   buf_cnt <= buf_cnt + 3'd1;
        2'b01:   buf_cnt <= buf_cnt - 3'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  assign {out_last, out_qid, out_data} = buf_mem[buf_rd_ptr];
  assign out_valid = (buf_cnt != 3'd0);
  assign busy      = (state != S_IDLE) || (buf_cnt != 3'd0);

  a_no_push_full: assert property (@(posedge rdclk) disable iff (reset)
    buf_push |-> (buf_cnt < 3'(BUF_DEPTH)));
  a_rden_onehot: assert property (@(posedge rdclk) disable iff (reset)
    $onehot0(q_rden));

endmodule
